// File: rtl/v_norm_fixed_to_float.sv
// ---------------------------------------------------------------------------
// v_norm_fixed_to_float
// Converts a 32-bit two's-complement fixed-point word with FRAC_BITS
// fractional bits into an IEEE-754 single-precision value. The magnitude is
// normalised iteratively, one left shift per clock, until its leading one
// reaches bit 31. The mantissa is truncated toward zero. This block produces
// no denormals, infinities or NaNs.
//
// Ports:
//   CLK           in   1   system clock, rising edge
//   RST_FF        in   1   asynchronous active-high reset
//   RST_FSM_FF    in   1   synchronous FSM abort; returns to IDLE, RESULT kept
//   Begin_FSM_FF  in   1   start request, sampled in IDLE or DONE
//   FIXED         in  32   signed fixed-point input
//   ACK_FF        out  1   conversion complete; RESULT valid while high
//   RESULT        out 32   {sign, exp[7:0], mant[22:0]}
// ---------------------------------------------------------------------------
module v_norm_fixed_to_float #(
  parameter int unsigned FRAC_BITS = 26
) (
  input  logic        CLK,
  input  logic        RST_FF,
  input  logic        RST_FSM_FF,
  input  logic        Begin_FSM_FF,
  input  logic [31:0] FIXED,
  output logic        ACK_FF,
  output logic [31:0] RESULT
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;

  // Exponent of a value whose leading one sits at bit 31 before any shifting.
  // Each shift performed in NORM lowers the exponent by one.
  localparam int unsigned EXP_BASE = 127 + 31 - FRAC_BITS;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ABS  = 3'd1;
  localparam logic [2:0] S_NORM = 3'd2;
  localparam logic [2:0] S_PACK = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [DATA_W-1:0] fixed_cap;
  logic [DATA_W-1:0] fixed_cap_next;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] mag_next;
  logic              sign;
  logic              sign_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              zero;
  logic              zero_next;
  logic              ack_next;
  logic [DATA_W-1:0] result_next;

  logic [DATA_W-1:0] mag_abs_c;
  logic [EXP_W-1:0]  exp_c;

  // Absolute value. 32'h80000000 maps onto itself, which is its correct
  // unsigned magnitude, so no overflow handling is needed.
  assign mag_abs_c = fixed_cap[DATA_W-1] ? (~fixed_cap + DATA_W'(1)) : fixed_cap;

  // Biased exponent. Modulo-256 subtraction matches a 9-bit computation
  // truncated to 8 bits; the legal FRAC_BITS range keeps it in 1..254.
  assign exp_c = EXP_W'(EXP_BASE) - {{(EXP_W-CNT_W){1'b0}}, cnt};

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      state     <= S_IDLE;
      fixed_cap <= '0;
      mag       <= '0;
      sign      <= 1'b0;
      cnt       <= '0;
      zero      <= 1'b0;
      ACK_FF    <= 1'b0;
      RESULT    <= '0;
    end else begin
      state     <= state_next;
      fixed_cap <= fixed_cap_next;
      mag       <= mag_next;
      sign      <= sign_next;
      cnt       <= cnt_next;
      zero      <= zero_next;
      ACK_FF    <= ack_next;
      RESULT    <= result_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    fixed_cap_next = fixed_cap;
    mag_next       = mag;
    sign_next      = sign;
    cnt_next       = cnt;
    zero_next      = zero;
    ack_next       = ACK_FF;
    result_next    = RESULT;

    if (RST_FSM_FF) begin
      // Abort: drop the handshake, keep the last RESULT.
      state_next = S_IDLE;
      ack_next   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Begin_FSM_FF) begin
            fixed_cap_next = FIXED;
            state_next     = S_ABS;
          end
        end

        S_ABS: begin
          sign_next = fixed_cap[DATA_W-1];
          mag_next  = mag_abs_c;
          cnt_next  = '0;
          zero_next = (fixed_cap == '0);
          // A zero input has no leading one, so normalisation is skipped.
          state_next = (fixed_cap == '0) ? S_PACK : S_NORM;
        end

        S_NORM: begin
          if (mag[DATA_W-1]) begin
            state_next = S_PACK;
          end else begin
            mag_next = {mag[DATA_W-2:0], 1'b0};
            cnt_next = cnt + CNT_W'(1);
          end
        end

        S_PACK: begin
          if (zero) begin
            result_next = '0;
          end else begin
            // The leading one at bit 31 is implicit; the next 23 bits form
            // the mantissa and the rest are truncated.
            result_next = {sign, exp_c, mag[DATA_W-2 -: MANT_W]};
          end
          ack_next   = 1'b1;
          state_next = S_DONE;
        end

        S_DONE: begin
          if (Begin_FSM_FF) begin
            ack_next       = 1'b0;
            fixed_cap_next = FIXED;
            state_next     = S_ABS;
          end
        end

        default: begin
          state_next = S_IDLE;
          ack_next   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v_norm_fixed_to_float.sv
// ---------------------------------------------------------------------------
// tb_v_norm_fixed_to_float
// Self-checking bench for v_norm_fixed_to_float: directed vector table,
// hand-written reset/abort/Begin-toggle sequences, and random conversions
// checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_v_norm_fixed_to_float;

  localparam int unsigned FRAC = 26;

  logic        clk;
  logic        rst;
  logic        rst_fsm;
  logic        begin_fsm;
  logic [31:0] fixed;
  logic        ack;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  v_norm_fixed_to_float #(.FRAC_BITS(FRAC)) dut (
    .CLK          (clk),
    .RST_FF       (rst),
    .RST_FSM_FF   (rst_fsm),
    .Begin_FSM_FF (begin_fsm),
    .FIXED        (fixed),
    .ACK_FF       (ack),
    .RESULT       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fx;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: value = fx / 2^FRAC. Locate the leading one of |fx|, derive
  // the exponent from its position and truncate the fraction to 23 bits.
  function automatic void model(input logic [31:0] fx, output logic [31:0] res,
                                output int lat);
    longint m;
    longint mant;
    int     p;
    int     e;
    if (fx == 32'h0) begin
      res = 32'h0;
      lat = 2;
      return;
    end
    m = fx[31] ? (64'h1_0000_0000 - longint'(fx)) : longint'(fx);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e    = 127 + p - int'(FRAC);
    mant = ((m << 23) >> p) & 64'h7F_FFFF;
    res  = {fx[31], 8'(e), 23'(mant)};
    lat  = 3 + (31 - p);
  endfunction

  // Issue one conversion and measure ACK latency from the Begin edge.
  task automatic convert(input logic [31:0] fx, input logic [31:0] exp_res,
                         input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    fixed     = fx;
    begin_fsm = 1'b1;
    @(posedge clk);
    #1;
    begin_fsm = 1'b0;
    fixed     = $urandom;
    check({name, " ack_low_after_begin"}, 32'(ack), 32'd0);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        lat = n;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result, exp_res);
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] held;
    logic [31:0] mres;
    logic [31:0] rv;
    int          mlat;
    int          ack_seen;
    int          lat;

    vecs[0] = '{32'h04000000, 32'h3F800000, 8};
    vecs[1] = '{32'hFC000000, 32'hBF800000, 8};
    vecs[2] = '{32'h02000000, 32'h3F000000, 9};
    vecs[3] = '{32'h80000000, 32'hC2000000, 3};
    vecs[4] = '{32'h00000001, 32'h32800000, 34};
    vecs[5] = '{32'h7FFFFFFF, 32'h41FFFFFF, 4};
    vecs[6] = '{32'h00000000, 32'h00000000, 2};

    rst       = 1'b1;
    rst_fsm   = 1'b0;
    begin_fsm = 1'b0;
    fixed     = 32'h0;
    #12;
    check("reset ack", 32'(ack), 32'd0);
    check("reset result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle ack", 32'(ack), 32'd0);

    // Directed table, run back-to-back (each Begin arrives in DONE).
    foreach (vecs[i]) begin
      convert(vecs[i].fx, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // ACK and RESULT hold in DONE until the next Begin.
    repeat (3) @(posedge clk);
    #1;
    check("done hold ack", 32'(ack), 32'd1);
    check("done hold result", result, 32'h0);

    // Zero then immediate +1.0 from DONE.
    convert(32'h04000000, 32'h3F800000, 8, "after_zero");

    // Synchronous FSM abort during NORM of a long conversion.
    held = result;
    @(negedge clk);
    fixed     = 32'h00000001;
    begin_fsm = 1'b1;
    @(posedge clk);
    #1;
    begin_fsm = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_fsm = 1'b1;
    @(posedge clk);
    #1;
    rst_fsm = 1'b0;
    check("fsm_rst ack", 32'(ack), 32'd0);
    check("fsm_rst result kept", result, held);
    ack_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (ack) ack_seen++;
    end
    check("fsm_rst no ack afterwards", 32'(ack_seen), 32'd0);
    check("fsm_rst result still kept", result, held);
    // Back in IDLE: a fresh conversion behaves normally.
    convert(32'h02000000, 32'h3F000000, 9, "after_fsm_rst");

    // Asynchronous reset in the middle of NORM, checked between edges.
    @(negedge clk);
    fixed     = 32'h00000001;
    begin_fsm = 1'b1;
    @(posedge clk);
    #1;
    begin_fsm = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst ack", 32'(ack), 32'd0);
    check("async rst result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Begin toggled throughout ABS/NORM/PACK is ignored.
    @(negedge clk);
    fixed     = 32'h04000000;
    begin_fsm = 1'b1;
    @(posedge clk);
    #1;
    fixed = 32'h00000001;
    lat   = 0;
    ack_seen = 0;
    for (int n = 1; n <= 8; n++) begin
      begin_fsm = n[0];
      @(posedge clk);
      #1;
      if (ack) begin
        ack_seen++;
        if (lat == 0) lat = n;
      end
    end
    begin_fsm = 1'b0;
    check("toggle latency", 32'(lat), 32'd8);
    check("toggle single ack", 32'(ack_seen), 32'd1);
    check("toggle result", result, 32'h3F800000);

    // Random conversions against the reference model.
    for (int i = 0; i < 150; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rv = -rv;
      if ($urandom_range(0, 15) == 0) rv = 32'h0;
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        rst_fsm = 1'b1;
        @(negedge clk);
        rst_fsm = 1'b0;
      end
      model(rv, mres, mlat);
      convert(rv, mres, mlat, $sformatf("rand%0d fx=%h", i, rv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
